// File: rtl/factor_checker.sv
// factor_checker: latches a packed question word, then checks player prime
// entries against the running remainder with a repeated-subtraction divider.
// Tracks misses, reports solve/fail, and accumulates a saturating score.
module factor_checker (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [25:0] QUESTION,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  output logic        BUSY,
  output logic        READY,
  output logic [9:0]  REMAIN,
  output logic [1:0]  LEVEL,
  output logic [1:0]  MISS,
  output logic        CORRECT,
  output logic        WRONG,
  output logic        SOLVED,
  output logic        FAIL,
  output logic [7:0]  SCORE
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DIV, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [9:0]  r_remain;
  logic [1:0]  r_level;
  logic [1:0]  r_miss;
  logic [7:0]  r_score;
  logic [9:0]  r_work;
  logic [9:0]  r_quot;
  logic [4:0]  r_p;
  logic        r_correct;
  logic        r_wrong;
  logic        r_solved;
  logic        r_fail;

  logic [4:0]  w_prime;
  logic        w_key_ok;
  logic [9:0]  w_load_n;
  logic        w_n_ok;
  logic        w_div_ge;
  logic        w_exact;
  logic        w_last_miss;
  logic        w_quot_one;
  logic [8:0]  w_score_sum;
  logic [7:0]  w_score_sat;
  logic        w_unused_codes;

  // Answer codes travel with the question word but are not needed here.
  assign w_unused_codes = ^QUESTION[13:0];

  assign w_load_n    = QUESTION[23:14];
  assign w_n_ok      = (w_load_n >= 10'd2);
  assign w_div_ge    = (r_work >= {5'd0, r_p});
  assign w_exact     = (r_work == 10'd0);
  assign w_last_miss = (r_miss == 2'd2);
  assign w_quot_one  = (r_quot == 10'd1);
  // Score add in 9 bits so the carry shows saturation.
  assign w_score_sum = {1'b0, r_score} + {7'd0, r_level} + 9'd1;
  assign w_score_sat = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  // Decode the key code to its prime; codes outside 1..9 are invalid.
  always_comb begin
    w_prime  = 5'd0;
    w_key_ok = 1'b1;
    case (KEY_CODE)
      4'd1:    w_prime = 5'd2;
      4'd2:    w_prime = 5'd3;
      4'd3:    w_prime = 5'd5;
      4'd4:    w_prime = 5'd7;
      4'd5:    w_prime = 5'd11;
      4'd6:    w_prime = 5'd13;
      4'd7:    w_prime = 5'd17;
      4'd8:    w_prime = 5'd19;
      4'd9:    w_prime = 5'd23;
      default: w_key_ok = 1'b0;
    endcase
  end

  // State register; reset overrides everything, including a division in flight.
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic; LOAD takes priority over any key in any state.
  always_comb begin
    w_state_next = r_state;
    if (LOAD) begin
      w_state_next = w_n_ok ? S_WAIT : S_DONE;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (KEY_VALID) begin
            if (w_key_ok)         w_state_next = S_DIV;
            else if (w_last_miss) w_state_next = S_DONE;
          end
        end
        S_DIV: begin
          if (!w_div_ge) begin
            if (w_exact) w_state_next = w_quot_one ? S_DONE : S_WAIT;
            else         w_state_next = w_last_miss ? S_DONE : S_WAIT;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Datapath: question latch, divider, miss/score bookkeeping and result pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_remain  <= 10'd0;
      r_level   <= 2'd0;
      r_miss    <= 2'd0;
      r_score   <= 8'd0;
      r_work    <= 10'd0;
      r_quot    <= 10'd0;
      r_p       <= 5'd0;
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
      r_solved  <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
      r_solved  <= 1'b0;
      r_fail    <= 1'b0;
      if (LOAD) begin
        r_level  <= QUESTION[25:24];
        r_remain <= w_load_n;
        r_miss   <= 2'd0;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (KEY_VALID) begin
              if (w_key_ok) begin
                r_work <= r_remain;
                r_quot <= 10'd0;
                r_p    <= w_prime;
              end else begin
                r_wrong <= 1'b1;
                r_miss  <= r_miss + 2'd1;
                r_fail  <= w_last_miss;
              end
            end
          end
          S_DIV: begin
            if (w_div_ge) begin
              r_work <= r_work - {5'd0, r_p};
              r_quot <= r_quot + 10'd1;
            end else if (w_exact) begin
              r_remain  <= r_quot;
              r_correct <= 1'b1;
              if (w_quot_one) begin
                r_solved <= 1'b1;
                r_score  <= w_score_sat;
              end
            end else begin
              r_wrong <= 1'b1;
              r_miss  <= r_miss + 2'd1;
              r_fail  <= w_last_miss;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode: status flags from state, pulses and values from registers.
  always_comb begin
    BUSY    = (r_state == S_DIV);
    READY   = (r_state == S_WAIT);
    REMAIN  = r_remain;
    LEVEL   = r_level;
    MISS    = r_miss;
    SCORE   = r_score;
    CORRECT = r_correct;
    WRONG   = r_wrong;
    SOLVED  = r_solved;
    FAIL    = r_fail;
  end

endmodule
